// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array tile responder.
// Holds the default geometry and number format, the one-hot FSM state type,
// and the accumulator-to-result quantizer sat_q().
package sa_pkg;

  localparam int SA_D_W   = 8;
  localparam int SA_FRAC  = 5;
  localparam int SA_ACC_W = 24;
  localparam int SA_ROWS  = 16;
  localparam int SA_COLS  = 16;
  localparam int SA_K_LEN = 128;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_RUN   = 4'b0010,
    ST_QUANT = 4'b0100,
    ST_DONE  = 4'b1000
  } sa_state_e;

  localparam logic signed [SA_ACC_W-1:0] Q_MAX = SA_ACC_W'((2 ** (SA_D_W - 1)) - 1);
  localparam logic signed [SA_ACC_W-1:0] Q_MIN = SA_ACC_W'(-(2 ** (SA_D_W - 1)));

  // Arithmetic shift right (floor toward -inf), then clamp to the D_W range.
  function automatic logic signed [SA_D_W-1:0] sat_q(input logic signed [SA_ACC_W-1:0] acc,
                                                     input int frac);
    logic signed [SA_ACC_W-1:0] sh;
    sh = acc >>> frac;
    if (sh > Q_MAX) begin
      return Q_MAX[SA_D_W-1:0];
    end else if (sh < Q_MIN) begin
      return Q_MIN[SA_D_W-1:0];
    end
    return sh[SA_D_W-1:0];
  endfunction

endpackage

// File: rtl/sa_tile_responder_if.sv
// Handshake/data bundle between the attention controller (master) and the
// tile responder (slave).
//   I_SA_CLEARN  : synchronous clear, active-low
//   I_SA_START   : start pulse
//   I_MAT_1      : SA_R x K_LEN left operand, element [row][k]
//   I_MAT_2      : K_LEN x SA_C right operand, element [k][col]
//   O_PE_SHIFT   : high while operands shift through the grid
//   O_SA_VLD     : result valid (level)
//   O_SA_RESULT  : SA_R x SA_C quantized tile, element [row][col]
interface sa_tile_responder_if
  import sa_pkg::*;
#(
  parameter int D_W   = SA_D_W,
  parameter int SA_R  = SA_ROWS,
  parameter int SA_C  = SA_COLS,
  parameter int K_LEN = SA_K_LEN
);

  logic                                  I_SA_CLEARN;
  logic                                  I_SA_START;
  logic [SA_R-1:0][K_LEN-1:0][D_W-1:0]   I_MAT_1;
  logic [K_LEN-1:0][SA_C-1:0][D_W-1:0]   I_MAT_2;
  logic                                  O_PE_SHIFT;
  logic                                  O_SA_VLD;
  logic [SA_R-1:0][SA_C-1:0][D_W-1:0]    O_SA_RESULT;

  modport master (
    output I_SA_CLEARN, I_SA_START, I_MAT_1, I_MAT_2,
    input  O_PE_SHIFT, O_SA_VLD, O_SA_RESULT
  );

  modport slave (
    input  I_SA_CLEARN, I_SA_START, I_MAT_1, I_MAT_2,
    output O_PE_SHIFT, O_SA_VLD, O_SA_RESULT
  );

endinterface

// File: rtl/sa_pe_mac.sv
// One output-stationary processing element.
//   clk_i, rst_i : clock, async active-high reset
//   clr_i        : synchronous zero of accumulator and pass-through registers
//   en_i         : accumulate/shift enable (grid is running)
//   a_i, b_i     : operands arriving from west / north
//   a_o, b_o     : registered operands forwarded east / south
//   acc_o        : signed accumulator
module sa_pe_mac #(
  parameter int D_W   = 8,
  parameter int ACC_W = 24
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [D_W-1:0]   a_i,
  input  logic [D_W-1:0]   b_i,
  output logic [D_W-1:0]   a_o,
  output logic [D_W-1:0]   b_o,
  output logic [ACC_W-1:0] acc_o
);

  logic [D_W-1:0]          a_q, b_q;
  logic [ACC_W-1:0]        acc_q, acc_d;
  logic signed [2*D_W-1:0] a_ext, b_ext, prod;

  // Extend before multiplying so the low 2*D_W bits are the exact signed product.
  assign a_ext = {{D_W{a_i[D_W-1]}}, a_i};
  assign b_ext = {{D_W{b_i[D_W-1]}}, b_i};
  assign prod  = a_ext * b_ext;
  assign acc_d = acc_q + {{(ACC_W-2*D_W){prod[2*D_W-1]}}, prod};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else if (clr_i) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else if (en_i) begin
      a_q   <= a_i;
      b_q   <= b_i;
      acc_q <= acc_d;
    end
  end

  assign a_o   = a_q;
  assign b_o   = b_q;
  assign acc_o = acc_q;

endmodule

// File: rtl/sa_tile_responder.sv
// Systolic-array tile responder: streams skewed operands into an SA_R x SA_C
// output-stationary MAC grid, quantizes the accumulators and presents the tile.
//   I_CLK       : clock
//   I_ASYN_RST  : async reset, active-high
//   sa_if       : slave side of the controller bundle (start/clear, operands,
//                 PE-shift indicator, valid, result tile)
// D_W, FRAC and ACC_W must match the sa_pkg defaults used by sat_q().
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for start
// ST_RUN   | feeding operands, counter t = 0..T-1, O_PE_SHIFT high
// ST_QUANT | one cycle: quantized accumulators registered into the result
// ST_DONE  | result valid; a new start launches another job
module sa_tile_responder
  import sa_pkg::*;
#(
  parameter int D_W   = SA_D_W,
  parameter int FRAC  = SA_FRAC,
  parameter int SA_R  = SA_ROWS,
  parameter int SA_C  = SA_COLS,
  parameter int K_LEN = SA_K_LEN,
  parameter int ACC_W = SA_ACC_W
) (
  input  logic            I_CLK,
  input  logic            I_ASYN_RST,
  sa_tile_responder_if.slave sa_if
);

  localparam int T  = K_LEN + SA_R + SA_C - 2;
  localparam int CW = $clog2(T);
  localparam int KW = $clog2(K_LEN);

  sa_state_e                          state_q, state_d;
  logic [CW-1:0]                      cnt_q, cnt_d;
  logic                               vld_q, vld_d;
  logic [SA_R-1:0][SA_C-1:0][D_W-1:0] result_q, result_d;
  logic                               run, grid_clr, quant;

  logic [SA_R-1:0][D_W-1:0]           west_a;
  logic [SA_C-1:0][D_W-1:0]           north_b;
  logic [SA_R-1:0][SA_C-1:0][D_W-1:0] a_pass, b_pass;
  logic [SA_R-1:0][SA_C-1:0][ACC_W-1:0] acc;
  logic                               pass_unused;

  assign run = (state_q == ST_RUN);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    vld_d    = 1'b0;
    grid_clr = 1'b0;
    quant    = 1'b0;
    if (!sa_if.I_SA_CLEARN) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      grid_clr = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (sa_if.I_SA_START) begin
            state_d  = ST_RUN;
            cnt_d    = '0;
            grid_clr = 1'b1;
          end
        end
        ST_RUN: begin
          if (cnt_q == CW'(T - 1)) begin
            state_d = ST_QUANT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_QUANT: begin
          quant   = 1'b1;
          state_d = ST_DONE;
        end
        ST_DONE: begin
          if (sa_if.I_SA_START) begin
            state_d  = ST_RUN;
            cnt_d    = '0;
            grid_clr = 1'b1;
          end else begin
            vld_d = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge I_CLK or posedge I_ASYN_RST) begin
    if (I_ASYN_RST) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      vld_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      vld_q    <= vld_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    result_d = result_q;
    if (quant) begin
      for (int i = 0; i < SA_R; i++) begin
        for (int j = 0; j < SA_C; j++) begin
          result_d[i][j] = sat_q(acc[i][j], FRAC);
        end
      end
    end
  end

  // Edge skew: row i sees MAT_1[i][t-i], column j sees MAT_2[t-j][j]; the
  // pass-through registers add the remaining j (resp. i) cycles so PE(i,j)
  // meets operand pair k at t = k+i+j. Outside the k window the edge feeds zero.
  always_comb begin
    int k;
    k       = 0;
    west_a  = '0;
    north_b = '0;
    if (run) begin
      for (int i = 0; i < SA_R; i++) begin
        k = int'(cnt_q) - i;
        if (k >= 0 && k < K_LEN) begin
          west_a[i] = sa_if.I_MAT_1[i][k[KW-1:0]];
        end
      end
      for (int j = 0; j < SA_C; j++) begin
        k = int'(cnt_q) - j;
        if (k >= 0 && k < K_LEN) begin
          north_b[j] = sa_if.I_MAT_2[k[KW-1:0]][j];
        end
      end
    end
  end

  for (genvar gi = 0; gi < SA_R; gi++) begin : g_row
    for (genvar gj = 0; gj < SA_C; gj++) begin : g_col
      logic [D_W-1:0] a_in, b_in;
      if (gj == 0) begin : g_west
        assign a_in = west_a[gi];
      end else begin : g_inner_a
        assign a_in = a_pass[gi][gj-1];
      end
      if (gi == 0) begin : g_north
        assign b_in = north_b[gj];
      end else begin : g_inner_b
        assign b_in = b_pass[gi-1][gj];
      end
      sa_pe_mac #(
        .D_W  (D_W),
        .ACC_W(ACC_W)
      ) u_pe (
        .clk_i(I_CLK),
        .rst_i(I_ASYN_RST),
        .clr_i(grid_clr),
        .en_i (run),
        .a_i  (a_in),
        .b_i  (b_in),
        .a_o  (a_pass[gi][gj]),
        .b_o  (b_pass[gi][gj]),
        .acc_o(acc[gi][gj])
      );
    end
  end

  // East and south edge outputs of the grid have no consumer.
  always_comb begin
    pass_unused = 1'b0;
    for (int i = 0; i < SA_R; i++) pass_unused = pass_unused ^ (^a_pass[i][SA_C-1]);
    for (int j = 0; j < SA_C; j++) pass_unused = pass_unused ^ (^b_pass[SA_R-1][j]);
  end

  assign sa_if.O_PE_SHIFT  = run;
  assign sa_if.O_SA_VLD    = vld_q;
  assign sa_if.O_SA_RESULT = result_q;

endmodule

// File: tb/tb_sa_tile_responder.sv
module tb_sa_tile_responder;

  localparam int R    = 16;
  localparam int C    = 16;
  localparam int K    = 128;
  localparam int LAT  = K + R + C;       // start edge 0 -> valid after edge T+2
  localparam int NSHF = K + R + C - 2;   // RUN length

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sa_tile_responder_if #(.D_W(8), .SA_R(R), .SA_C(C), .K_LEN(K)) sa_if ();

  sa_tile_responder dut (
    .I_CLK     (clk),
    .I_ASYN_RST(rst),
    .sa_if     (sa_if)
  );

  int m1 [R][K];
  int m2 [K][C];
  int exp_r [R][C];
  int tests = 0;
  int fails = 0;

  function automatic int rnd8();
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  // Reference: plain matrix product, floor divide by 32, clamp to int8.
  function automatic void model();
    for (int i = 0; i < R; i++) begin
      for (int j = 0; j < C; j++) begin
        int s;
        int q;
        s = 0;
        for (int k = 0; k < K; k++) s += m1[i][k] * m2[k][j];
        q = s >>> 5;
        if (q > 127) q = 127;
        if (q < -128) q = -128;
        exp_r[i][j] = q;
      end
    end
  endfunction

  function automatic void load();
    for (int i = 0; i < R; i++)
      for (int k = 0; k < K; k++) sa_if.I_MAT_1[i][k] = 8'(m1[i][k]);
    for (int k = 0; k < K; k++)
      for (int j = 0; j < C; j++) sa_if.I_MAT_2[k][j] = 8'(m2[k][j]);
  endfunction

  function automatic int res(input int i, input int j);
    return int'($signed(sa_if.O_SA_RESULT[i][j]));
  endfunction

  function automatic int mism(output int fi, output int fj, output int act);
    int n;
    n = 0; fi = -1; fj = -1; act = 0;
    for (int i = 0; i < R; i++)
      for (int j = 0; j < C; j++)
        if (res(i, j) != exp_r[i][j]) begin
          if (n == 0) begin fi = i; fj = j; act = res(i, j); end
          n++;
        end
    return n;
  endfunction

  // Pulses start, optionally re-pulses it at RUN cycle inject_at, and waits
  // (bounded) for valid. lat = -1 when the bound expires.
  task automatic run_job(input int inject_at, output int lat, output int shifts, output int vld0);
    @(negedge clk);
    sa_if.I_SA_START = 1'b1;
    @(negedge clk);
    sa_if.I_SA_START = 1'b0;
    vld0   = int'(sa_if.O_SA_VLD);
    shifts = int'(sa_if.O_PE_SHIFT);
    lat    = -1;
    for (int n = 1; n <= 400; n++) begin
      sa_if.I_SA_START = (n - 1 == inject_at);
      @(negedge clk);
      if (sa_if.O_PE_SHIFT) shifts++;
      if (sa_if.O_SA_VLD) begin
        lat = n;
        break;
      end
    end
    sa_if.I_SA_START = 1'b0;
  endtask

  task automatic job_and_check(input string name, input int inject_at);
    int lat, shifts, vld0, fi, fj, act, n;
    model();
    load();
    run_job(inject_at, lat, shifts, vld0);
    tests++;
    if (vld0 !== 0) begin
      fails++;
      $display("FAIL %s_vld_drop: vld after start edge got %0d want 0", name, vld0);
    end
    tests++;
    if (lat !== LAT) begin
      fails++;
      $display("FAIL %s_latency: got %0d edges want %0d", name, lat, LAT);
    end
    tests++;
    if (shifts !== NSHF) begin
      fails++;
      $display("FAIL %s_pe_shift: high %0d cycles want %0d", name, shifts, NSHF);
    end
    n = mism(fi, fj, act);
    tests++;
    if (n !== 0) begin
      fails++;
      $display("FAIL %s_result: %0d wrong, [%0d][%0d] got %0d want %0d",
               name, n, fi, fj, act, exp_r[fi][fj]);
    end
  endtask

  task automatic test_reset();
    int nz;
    rst = 1'b1;
    sa_if.I_SA_CLEARN = 1'b1;
    sa_if.I_SA_START  = 1'b0;
    sa_if.I_MAT_1 = '0;
    sa_if.I_MAT_2 = '0;
    #12;
    tests++;
    if (sa_if.O_PE_SHIFT !== 1'b0 || sa_if.O_SA_VLD !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctrl: shift=%b vld=%b want 0 0", sa_if.O_PE_SHIFT, sa_if.O_SA_VLD);
    end
    nz = 0;
    for (int i = 0; i < R; i++) for (int j = 0; j < C; j++) if (res(i, j) != 0) nz++;
    tests++;
    if (nz !== 0) begin
      fails++;
      $display("FAIL reset_result: %0d nonzero elements want 0", nz);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_scaling();
    for (int i = 0; i < R; i++) for (int k = 0; k < K; k++) m1[i][k] = 32;
    for (int k = 0; k < K; k++) for (int j = 0; j < C; j++) m2[k][j] = (k == j) ? 3 : 0;
    job_and_check("scaling", -1);
  endtask

  task automatic test_identity();
    int n;
    for (int i = 0; i < R; i++) for (int k = 0; k < K; k++) m1[i][k] = (k == i) ? 32 : 0;
    for (int k = 0; k < K; k++) for (int j = 0; j < C; j++) m2[k][j] = rnd8();
    job_and_check("identity", -1);
    n = 0;
    for (int i = 0; i < R; i++) for (int j = 0; j < C; j++) if (res(i, j) != m2[i][j]) n++;
    tests++;
    if (n !== 0) begin
      fails++;
      $display("FAIL identity_vs_mat2: %0d elements differ from MAT_2 want 0", n);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < R; i++) for (int k = 0; k < K; k++) m1[i][k] = 127;
    for (int k = 0; k < K; k++) for (int j = 0; j < C; j++) m2[k][j] = 127;
    job_and_check("saturation", -1);
    tests++;
    if (res(R - 1, C - 1) !== 127) begin
      fails++;
      $display("FAIL saturation_corner: got %0d want 127", res(R - 1, C - 1));
    end
  endtask

  task automatic test_floor();
    int sel;
    for (int i = 0; i < R; i++) for (int k = 0; k < K; k++) m1[i][k] = -1;
    for (int k = 0; k < K; k++) for (int j = 0; j < C; j++) m2[k][j] = 0;
    for (int j = 0; j < C; j++) begin
      sel = int'($urandom_range(0, K - 1));
      m2[sel][j] = 1;
    end
    job_and_check("floor", -1);
    tests++;
    if (res(3, 7) !== -1) begin
      fails++;
      $display("FAIL floor_elem: got %0d want -1", res(3, 7));
    end
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < R; i++) for (int k = 0; k < K; k++) m1[i][k] = rnd8();
      for (int k = 0; k < K; k++) for (int j = 0; j < C; j++) m2[k][j] = rnd8();
      job_and_check("b2b", -1);
    end
  endtask

  task automatic test_start_in_run();
    for (int i = 0; i < R; i++) for (int k = 0; k < K; k++) m1[i][k] = int'($urandom_range(0, 15)) - 8;
    for (int k = 0; k < K; k++) for (int j = 0; j < C; j++) m2[k][j] = rnd8();
    job_and_check("start_in_run", 20);
  endtask

  task automatic test_clear_mid_run();
    int fi, fj, act, n;
    // exp_r still describes the tile currently on the output
    @(negedge clk);
    sa_if.I_SA_START = 1'b1;
    @(negedge clk);
    sa_if.I_SA_START = 1'b0;
    repeat (50) @(negedge clk);
    sa_if.I_SA_CLEARN = 1'b0;
    @(negedge clk);
    sa_if.I_SA_CLEARN = 1'b1;
    tests++;
    if (sa_if.O_PE_SHIFT !== 1'b0 || sa_if.O_SA_VLD !== 1'b0) begin
      fails++;
      $display("FAIL clear_ctrl: shift=%b vld=%b want 0 0", sa_if.O_PE_SHIFT, sa_if.O_SA_VLD);
    end
    n = mism(fi, fj, act);
    tests++;
    if (n !== 0) begin
      fails++;
      $display("FAIL clear_holds_result: %0d changed, [%0d][%0d] got %0d want %0d",
               n, fi, fj, act, exp_r[fi][fj]);
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < R; i++) for (int k = 0; k < K; k++) m1[i][k] = rnd8();
    for (int k = 0; k < K; k++) for (int j = 0; j < C; j++) m2[k][j] = int'($urandom_range(0, 7)) - 4;
    job_and_check("after_clear", -1);
  endtask

  task automatic test_async_reset();
    int nz;
    @(negedge clk);
    sa_if.I_SA_START = 1'b1;
    @(negedge clk);
    sa_if.I_SA_START = 1'b0;
    repeat (30) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    tests++;
    if (sa_if.O_PE_SHIFT !== 1'b0 || sa_if.O_SA_VLD !== 1'b0) begin
      fails++;
      $display("FAIL async_rst_ctrl: shift=%b vld=%b want 0 0", sa_if.O_PE_SHIFT, sa_if.O_SA_VLD);
    end
    nz = 0;
    for (int i = 0; i < R; i++) for (int j = 0; j < C; j++) if (res(i, j) != 0) nz++;
    tests++;
    if (nz !== 0) begin
      fails++;
      $display("FAIL async_rst_result: %0d nonzero elements want 0", nz);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_start_and_clear();
    int shf;
    @(negedge clk);
    sa_if.I_SA_START  = 1'b1;
    sa_if.I_SA_CLEARN = 1'b0;
    @(negedge clk);
    sa_if.I_SA_START  = 1'b0;
    sa_if.I_SA_CLEARN = 1'b1;
    shf = int'(sa_if.O_PE_SHIFT);
    repeat (4) @(negedge clk) shf += int'(sa_if.O_PE_SHIFT);
    tests++;
    if (shf !== 0 || sa_if.O_SA_VLD !== 1'b0) begin
      fails++;
      $display("FAIL start_clear: shift cycles=%0d vld=%b want 0 0", shf, sa_if.O_SA_VLD);
    end
  endtask

  initial begin
    test_reset();
    test_scaling();
    test_identity();
    test_saturation();
    test_floor();
    test_back_to_back();
    test_start_in_run();
    test_clear_mid_run();
    test_async_reset();
    test_start_and_clear();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
